// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg -- shared definitions for the memory sequencer.
//   state_e  : 3-bit FSM state encoding for mem_seq_ctrl
//   OP_READ / OP_WRITE : encoding of the latched operation
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAR     = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl -- Moore FSM sequencing one MAR/MDR memory access.
//   IDLE -> MAR -> ACCESS -> (CAPTURE, read only) -> DONE -> IDLE
// Parameters:
//   WAIT_MAX  : ACCESS cycles allowed before timeout (1..255)
// Ports:
//   clk, reset (async, active-high)
//   start_rd, start_wr : operation requests, sampled only in IDLE (read wins)
//   mem_ready          : memory acknowledge during ACCESS
//   mar_in, mdr_in     : MAR / MDR load strobes
//   mdr_read           : MDR source select (1 = memory, 0 = bus)
//   mem_rd, mem_wr     : memory requests
//   busy, done, err    : status (done is a 1-cycle pulse, err is sticky)
// Configuration:
//   MEM_TIMEOUT_EN : when defined, an 8-bit ACCESS counter aborts the access
//                    to DONE with err set after WAIT_MAX cycles; otherwise
//                    ACCESS waits forever and err is constant 0.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start_rd,
  input  logic start_wr,
  input  logic mem_ready,
  output logic mar_in,
  output logic mdr_in,
  output logic mdr_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_range
    $error("mem_seq_ctrl: WAIT_MAX must be in 1..255");
  end

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   start;
  logic   timeout;

  assign start = start_rd | start_wr;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Counter holds the number of ACCESS cycles already completed; it reaches
  // CNT_LAST during the WAIT_MAX-th ACCESS cycle.
  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_ACCESS) cnt_d = cnt_q + 8'd1;
    err_d = err_q;
    if (state_q == ST_IDLE && start) begin
      err_d = 1'b0;
    end else if (state_q == ST_ACCESS && !mem_ready && timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MAR;
          op_d    = start_rd ? OP_READ : OP_WRITE;
        end
      end
      ST_MAR:     state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ready) begin
          state_d = (op_q == OP_READ) ? ST_CAPTURE : ST_DONE;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode (registered state and latched op only)
  always_comb begin
    mar_in   = '0;
    mdr_in   = '0;
    mdr_read = '0;
    mem_rd   = '0;
    mem_wr   = '0;
    done     = '0;
    busy     = (state_q != ST_IDLE);
    unique case (state_q)
      ST_MAR:    mar_in = 1'b1;
      ST_ACCESS: begin
        mem_rd = (op_q == OP_READ);
        mem_wr = (op_q == OP_WRITE);
      end
      ST_CAPTURE: begin
        mdr_in   = 1'b1;
        mdr_read = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

endmodule
